// File: rtl/user_input_pkg.sv
`default_nettype none
// ============================================================================
// user_input_pkg : shared types and constants for the push-button/DIP debouncer
// Rev 1.0
// ============================================================================
package user_input_pkg;

   localparam int SYNC_STAGES = 2;

   typedef enum logic [1:0] {
      RELEASED  = 2'd0,
      PRESSED   = 2'd1,
      LONG_HELD = 2'd2
   } chan_state_t;

   // Clock cycles per millisecond tick, rounded to the nearest integer.
   function automatic int calc_tick_div(input real freq_hz);
      return int'(freq_hz / 1000.0);
   endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_channel.sv
`default_nettype none
// ============================================================================
// debounce_channel : synchronizer, debounce qualifier and press/release FSM for
// one input; long-press event compiled in with USER_INPUT_LONG_PRESS_EN. Rev 1.0
// ============================================================================
module debounce_channel
   import user_input_pkg::*;
#(
   parameter int DEBOUNCE_MS   = 20,
`ifdef USER_INPUT_LONG_PRESS_EN
   parameter int LONG_PRESS_MS = 1000,
`endif
   parameter bit ACTIVE_LOW    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ms_tick,
   input  logic pin,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic long_pulse
);

   localparam int                     CNT_W       = $clog2(DEBOUNCE_MS + 1);
   localparam logic [CNT_W-1:0]       CNT_LAST    = CNT_W'(DEBOUNCE_MS - 1);
   localparam logic [1:0]             ST_RELEASED = 2'(RELEASED);
   localparam logic [1:0]             ST_PRESSED  = 2'(PRESSED);
   localparam logic [SYNC_STAGES-1:0] SYNC_IDLE   = {SYNC_STAGES{ACTIVE_LOW}};

   logic [SYNC_STAGES-1:0] sync_ff;
   logic [CNT_W-1:0]       cnt;
   logic [1:0]             state;
   logic                   sample;
   logic                   accept;

   // Normalized so that 1 always means pressed, whatever the pin polarity.
   assign sample = sync_ff[SYNC_STAGES-1] ^ ACTIVE_LOW;
   assign level  = (state != ST_RELEASED);

   always_comb begin
      accept = (sample != level) && ms_tick && (cnt == CNT_LAST);
   end

`ifdef USER_INPUT_LONG_PRESS_EN
   localparam int                LONG_W       = $clog2(LONG_PRESS_MS + 1);
   localparam logic [LONG_W-1:0] LONG_LAST    = LONG_W'(LONG_PRESS_MS - 1);
   localparam logic [1:0]        ST_LONG_HELD = 2'(LONG_HELD);

   logic [LONG_W-1:0] long_cnt;
   logic              long_due;

   // A release accepted on the same tick wins, so long never meets release.
   always_comb begin
      long_due = (state == ST_PRESSED) && ms_tick && !accept && (long_cnt == LONG_LAST);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         long_cnt   <= '0;
         long_pulse <= 1'b0;
      end else begin
         long_pulse <= long_due;
         if (state != ST_PRESSED) begin
            long_cnt <= '0;
         end else if (ms_tick && !accept && (long_cnt != LONG_LAST)) begin
            long_cnt <= long_cnt + 1'b1;
         end
      end
   end
`else
   assign long_pulse = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_ff       <= SYNC_IDLE;
         cnt           <= '0;
         state         <= ST_RELEASED;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         sync_ff       <= {sync_ff[SYNC_STAGES-2:0], pin};
         press_pulse   <= accept & sample;
         release_pulse <= accept & ~sample;

         if ((sample == level) || accept) begin
            cnt <= '0;
         end else if (ms_tick) begin
            cnt <= cnt + 1'b1;
         end

         case (state)
            ST_RELEASED: begin
               if (accept && sample) state <= ST_PRESSED;
            end
            ST_PRESSED: begin
               if (accept && !sample) state <= ST_RELEASED;
`ifdef USER_INPUT_LONG_PRESS_EN
               else if (long_due) state <= ST_LONG_HELD;
`endif
            end
`ifdef USER_INPUT_LONG_PRESS_EN
            ST_LONG_HELD: begin
               if (accept && !sample) state <= ST_RELEASED;
            end
`endif
            default: state <= ST_RELEASED;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/user_input_debounce.sv
`default_nettype none
// ============================================================================
// user_input_debounce : ms prescaler plus one debounce_channel per board input.
// Optional long-press events with USER_INPUT_LONG_PRESS_EN. Rev 1.0
// ============================================================================
module user_input_debounce
   import user_input_pkg::*;
#(
   parameter int  NUM_INPUTS    = 4,
   parameter real CLK_FREQUENCY = 12.0e6,
   parameter int  DEBOUNCE_MS   = 20,
   parameter int  LONG_PRESS_MS = 1000,
   parameter bit  ACTIVE_LOW    = 1'b1
) (
   input  logic                  clk_12mhz,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] btn_pin,
   output logic [NUM_INPUTS-1:0] btn_level,
   output logic [NUM_INPUTS-1:0] btn_press,
   output logic [NUM_INPUTS-1:0] btn_release,
   output logic [NUM_INPUTS-1:0] btn_long,
   output logic                  ms_tick
);

   localparam int               TICK_DIV = calc_tick_div(CLK_FREQUENCY);
   localparam int               PRE_W    = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   if ((NUM_INPUTS < 1) || (NUM_INPUTS > 16) || (TICK_DIV < 2) ||
       (DEBOUNCE_MS < 1) || (LONG_PRESS_MS < 1)) begin : g_param_check
      $error("user_input_debounce: parameter out of range");
   end

   logic [PRE_W-1:0] prescale;

   always_ff @(posedge clk_12mhz) begin
      if (!rst_n) begin
         prescale <= '0;
      end else if (prescale == PRE_LAST) begin
         prescale <= '0;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   assign ms_tick = (prescale == PRE_LAST);

   for (genvar ch = 0; ch < NUM_INPUTS; ch++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_MS   (DEBOUNCE_MS),
`ifdef USER_INPUT_LONG_PRESS_EN
         .LONG_PRESS_MS (LONG_PRESS_MS),
`endif
         .ACTIVE_LOW    (ACTIVE_LOW)
      ) u_chan (
         .clk           (clk_12mhz),
         .rst_n         (rst_n),
         .ms_tick       (ms_tick),
         .pin           (btn_pin[ch]),
         .level         (btn_level[ch]),
         .press_pulse   (btn_press[ch]),
         .release_pulse (btn_release[ch]),
         .long_pulse    (btn_long[ch])
      );
   end

endmodule
`default_nettype wire
